// File: rtl/import_triplet_serializer.sv
// import_triplet_serializer
// Captures an (a, b, c) triple on a start pulse and streams it out as one
// frame over a valid/ready interface: a, b, c and, when SEND_SUM=1, a
// trailing checksum beat (a+b+c truncated to WIDTH). Completed frames are
// counted in o_frames, which wraps.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | no frame in progress, waiting for i_start
// ST_SEND_A    | beat 0 (a) presented, waiting for i_ready
// ST_SEND_B    | beat 1 (b) presented, waiting for i_ready
// ST_SEND_C    | beat 2 (c) presented; final beat when SEND_SUM=0
// ST_SEND_SUM  | beat 3 (checksum) presented; always the final beat

module import_triplet_serializer #(
    parameter int WIDTH     = 10,
    parameter bit SEND_SUM  = 1'b1,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    input  logic [WIDTH-1:0]     i_c,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_data,
    output logic [1:0]           o_index,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_drop,
    output logic [CNT_WIDTH-1:0] o_frames
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_A,
        ST_SEND_B,
        ST_SEND_C,
        ST_SEND_SUM
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] c_q;
    logic [WIDTH-1:0] sum_q;

    logic xfer;
    logic final_xfer;
    logic start_ok;

    // A beat moves on valid&ready; o_last marks the final beat, so a final
    // transfer frees the holding registers in the same cycle and a new start
    // can be accepted without a bubble.
    assign xfer       = o_valid & i_ready;
    assign final_xfer = xfer & o_last;
    assign start_ok   = i_start & ((state == ST_IDLE) | final_xfer);

    // Frame sequencer: capture, beat advance, frame count and drop flag.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state    <= ST_IDLE;
            b_q      <= '0;
            c_q      <= '0;
            sum_q    <= '0;
            o_valid  <= 1'b0;
            o_data   <= '0;
            o_index  <= '0;
            o_last   <= 1'b0;
            o_busy   <= 1'b0;
            o_drop   <= 1'b0;
            o_frames <= '0;
        end else begin
            o_drop <= i_start & ~start_ok;

            if (final_xfer) begin
                o_frames <= o_frames + 1'b1;
            end

            if (start_ok) begin
                // a goes straight to the output; only b, c and the sum are held
                b_q     <= i_b;
                c_q     <= i_c;
                sum_q   <= i_a + i_b + i_c;
                state   <= ST_SEND_A;
                o_valid <= 1'b1;
                o_busy  <= 1'b1;
                o_data  <= i_a;
                o_index <= 2'd0;
                o_last  <= 1'b0;
            end else if (final_xfer) begin
                state   <= ST_IDLE;
                o_valid <= 1'b0;
                o_busy  <= 1'b0;
                o_data  <= '0;
                o_index <= 2'd0;
                o_last  <= 1'b0;
            end else if (xfer) begin
                case (state)
                    ST_SEND_A: begin
                        state   <= ST_SEND_B;
                        o_data  <= b_q;
                        o_index <= 2'd1;
                        o_last  <= 1'b0;
                    end
                    ST_SEND_B: begin
                        state   <= ST_SEND_C;
                        o_data  <= c_q;
                        o_index <= 2'd2;
                        o_last  <= ~SEND_SUM;
                    end
                    ST_SEND_C: begin
                        // only reached with SEND_SUM=1; otherwise c was final
                        state   <= ST_SEND_SUM;
                        o_data  <= sum_q;
                        o_index <= 2'd3;
                        o_last  <= 1'b1;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_import_triplet_serializer.sv
// Bench for import_triplet_serializer: two instances (with and without the
// checksum beat) share one stimulus stream and are compared every cycle
// against a queue-of-beats reference model.

module tb_import_triplet_serializer;

    localparam int W = 10;

    logic         i_clk   = 1'b0;
    logic         i_rst   = 1'b0;
    logic         i_start = 1'b0;
    logic         i_ready = 1'b0;
    logic [W-1:0] i_a     = '0;
    logic [W-1:0] i_b     = '0;
    logic [W-1:0] i_c     = '0;

    logic         v1, l1, b1, dr1;
    logic [W-1:0] d1;
    logic [1:0]   x1;
    logic [7:0]   f1;
    logic         v0, l0, b0, dr0;
    logic [W-1:0] d0;
    logic [1:0]   x0;
    logic [7:0]   f0;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    import_triplet_serializer #(.WIDTH(W), .SEND_SUM(1'b1), .CNT_WIDTH(8)) dut_sum (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_a(i_a), .i_b(i_b), .i_c(i_c),
        .o_valid(v1), .i_ready(i_ready), .o_data(d1), .o_index(x1),
        .o_last(l1), .o_busy(b1), .o_drop(dr1), .o_frames(f1)
    );

    import_triplet_serializer #(.WIDTH(W), .SEND_SUM(1'b0), .CNT_WIDTH(8)) dut_nosum (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_a(i_a), .i_b(i_b), .i_c(i_c),
        .o_valid(v0), .i_ready(i_ready), .o_data(d0), .o_index(x0),
        .o_last(l0), .o_busy(b0), .o_drop(dr0), .o_frames(f0)
    );

    // Observed vector: {valid, busy, drop, frames, beat}; beat fields only
    // matter while valid, so they are masked otherwise.
    logic [23:0] obs [2];
    assign obs[0] = {v1, b1, dr1, f1, v1 ? {d1, x1, l1} : 13'd0};
    assign obs[1] = {v0, b0, dr0, f0, v0 ? {d0, x0, l0} : 13'd0};

    // Reference model: model 0 = 4-beat frames, model 1 = 3-beat frames.
    // Each holds the list of beats still to be sent as {data, index, last}.
    logic [12:0] mq [2][8];
    int          mcnt [2];
    int          mfr  [2];
    bit          mdr  [2];

    always @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int m = 0; m < 2; m++) begin
                mcnt[m] = 0;
                mfr[m]  = 0;
                mdr[m]  = 1'b0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                bit busy, xfer, fin, acc;
                int nb, s;
                nb   = (m == 0) ? 4 : 3;
                busy = (mcnt[m] != 0);
                xfer = busy && i_ready;
                fin  = xfer && mq[m][0][0];
                acc  = i_start && (!busy || fin);
                mdr[m] = i_start && !acc;
                if (xfer) begin
                    for (int k = 0; k < 7; k++) mq[m][k] = mq[m][k+1];
                    mcnt[m] = mcnt[m] - 1;
                end
                if (fin) mfr[m] = (mfr[m] + 1) % 256;
                if (acc) begin
                    s = (int'(i_a) + int'(i_b) + int'(i_c)) % 1024;
                    mq[m][0] = {i_a, 2'd0, 1'b0};
                    mq[m][1] = {i_b, 2'd1, 1'b0};
                    mq[m][2] = {i_c, 2'd2, (nb == 3) ? 1'b1 : 1'b0};
                    mq[m][3] = {W'(s), 2'd3, 1'b1};
                    mcnt[m]  = nb;
                end
            end
        end
    end

    function automatic logic [23:0] exp_vec(input int m);
        logic v;
        v = (mcnt[m] != 0);
        return {v, v, mdr[m], 8'(mfr[m]), v ? mq[m][0] : 13'd0};
    endfunction

    task automatic tick();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic test_reset();
        i_rst = 1'b0;
        tick();
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m] !== 24'd0) begin
                errors++;
                $display("FAIL reset dut%0d: got %h want %h", m, obs[m], 24'd0);
            end
        end
        i_rst = 1'b1;
        tick();
    endtask

    task automatic test_zero_frame();
        i_a = 0; i_b = 0; i_c = 0; i_ready = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL zero_frame dut%0d cyc%0d: got %h want %h", m, cyc, obs[m], exp_vec(m));
                end
            end
            tick();
        end
    endtask

    task automatic test_sum_wrap();
        i_a = 10'd1023; i_b = 10'd1; i_c = 10'd2; i_ready = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_a = 10'd5; i_b = 10'd6; i_c = 10'd7;
        for (int cyc = 0; cyc < 5; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL sum_wrap dut%0d cyc%0d: got %h want %h", m, cyc, obs[m], exp_vec(m));
                end
            end
            tick();
        end
    endtask

    task automatic test_stall();
        i_a = 10'd300; i_b = 10'd1; i_c = 10'd77; i_ready = 1'b0; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            checks++;
            if (!(v1 === 1'b1 && d1 === 10'd1 && x1 === 2'd1)) begin
                errors++;
                $display("FAIL stall_hold cyc%0d: got v=%0b d=%0d i=%0d want v=1 d=1 i=1", cyc, v1, d1, x1);
            end
            tick();
        end
        i_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL stall_resume dut%0d cyc%0d: got %h want %h", m, cyc, obs[m], exp_vec(m));
                end
            end
            tick();
        end
    endtask

    task automatic test_drop();
        i_a = 10'd11; i_b = 10'd22; i_c = 10'd33; i_ready = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        i_a = 10'd400; i_b = 10'd500; i_c = 10'd600; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        checks++;
        if (!(dr1 === 1'b1 && d1 === 10'd33 && x1 === 2'd2)) begin
            errors++;
            $display("FAIL drop_pulse: got drop=%0b d=%0d i=%0d want drop=1 d=33 i=2", dr1, d1, x1);
        end
        for (int cyc = 0; cyc < 5; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL drop dut%0d cyc%0d: got %h want %h", m, cyc, obs[m], exp_vec(m));
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back(input int cycles, input string name);
        i_ready = 1'b1;
        i_start = 1'b1;
        for (int cyc = 0; cyc < cycles; cyc++) begin
            i_a = W'($urandom); i_b = W'($urandom); i_c = W'($urandom);
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL %s dut%0d cyc%0d: got %h want %h", name, m, cyc, obs[m], exp_vec(m));
                end
            end
        end
        i_start = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            i_start = ($urandom_range(0, 3) == 0);
            i_ready = ($urandom_range(0, 3) != 0);
            i_a = W'($urandom); i_b = W'($urandom); i_c = W'($urandom);
            tick();
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL random dut%0d cyc%0d: got %h want %h", m, cyc, obs[m], exp_vec(m));
                end
            end
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) tick();
    endtask

    task automatic test_reset_mid();
        i_a = 10'd9; i_b = 10'd8; i_c = 10'd7; i_ready = 1'b1; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        tick();
        tick();
        checks++;
        if (x1 !== 2'd2) begin
            errors++;
            $display("FAIL reset_mid_setup: got index %0d want 2", x1);
        end
        i_rst = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            checks++;
            if (obs[m] !== 24'd0) begin
                errors++;
                $display("FAIL reset_mid dut%0d: got %h want %h", m, obs[m], 24'd0);
            end
        end
        tick();
        i_rst = 1'b1;
        i_a = 10'd123; i_b = 10'd45; i_c = 10'd6; i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            for (int m = 0; m < 2; m++) begin
                checks++;
                if (obs[m] !== exp_vec(m)) begin
                    errors++;
                    $display("FAIL reset_restart dut%0d cyc%0d: got %h want %h", m, cyc, obs[m], exp_vec(m));
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_sum_wrap();
        test_stall();
        test_drop();
        test_back_to_back(24, "back_to_back");
        test_random();
        test_back_to_back(1040, "frame_wrap");
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
